// File: rtl/frame_read_sm.sv
// Frame buffer readout: issues one frame of sequential RAM reads on start and streams the
// pixels through a 2-entry skid buffer with sof/eol/eof markers, then waits for ack.
module frame_read_sm #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  output logic              ren,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              started,
  output logic              done,
  output logic              error
);
  localparam int CW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int RW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W*FRAME_H-1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(FRAME_W-1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(FRAME_H-1);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              wptr_q, rptr_q, infl_q;
  logic [1:0]        cnt_q, occ_nxt;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic              push, pop, last_rd;

  assign push      = infl_q;
  assign pop       = pix_valid & pix_ready;
  assign pix_valid = (cnt_q != 2'd0);
  assign pix_data  = buf_q[rptr_q];
  assign rd_addr   = addr_q;

  // Occupancy after this edge if no new read is issued; counts data still in the RAM pipe.
  assign occ_nxt = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign ren     = (state_q == ST_READ) && (occ_nxt < 2'd2);
  assign last_rd = ren && (addr_q == LAST_ADDR);

  assign pix_sof = pix_valid && (col_q == '0) && (row_q == '0);
  assign pix_eol = pix_valid && (col_q == LAST_COL);
  assign pix_eof = pix_eol && (row_q == LAST_ROW);

  assign started = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);
  assign error   = (state_q == ST_ERROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT:  if (start) state_d = ST_READ;
      ST_READ:  if (last_rd) state_d = ST_DRAIN;
      // Leave as the final pixel transfers so done follows eof without a bubble.
      ST_DRAIN: if (occ_nxt == 2'd0) state_d = ST_DONE;
      ST_DONE:  if (ack) state_d = ST_WAIT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      addr_q   <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      infl_q   <= 1'b0;
      cnt_q    <= 2'd0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= ren;
      if (state_q == ST_WAIT) addr_q <= '0;
      else if (ren)           addr_q <= last_rd ? '0 : addr_q + ADDR_W'(1);
      if (push) begin
        buf_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else if (!started) begin
        col_q <= '0;
        row_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_frame_read_sm.sv
// Directed bench: a 4x3 instance for handshake/stall/reset cases and a default-size
// instance for the full 320x240 frame.
module tb_frame_read_sm;
  localparam int W = 4, H = 3, AW = 4, DW = 8;

  logic          clk, reset, start, ack, pix_ready;
  logic          ren, pix_valid, pix_sof, pix_eol, pix_eof, started, done, error;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, pix_data;

  logic        b_start, b_ren, b_valid, b_ready, b_sof, b_eol, b_eof, b_started, b_done, b_error;
  logic [16:0] b_rd_addr;
  logic [15:0] b_rd_data, b_pix_data;

  int nvec = 0, nerr = 0, cyc = 0, eof_cyc = 0, done_cyc = 0;
  int issued = 0, xfer = 0;
  logic [DW-1:0] dq[$];
  logic [2:0]    fq[$];
  logic          stall_v = 1'b0;
  logic [DW-1:0] stall_d = '0;
  int bx = 0, beol = 0, beof = 0, bsof = 0, blast = 0;

  frame_read_sm #(.FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .ren(ren), .rd_addr(rd_addr),
    .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .started(started),
    .done(done), .error(error));

  frame_read_sm big (
    .clk(clk), .reset(reset), .start(b_start), .ack(1'b0), .ren(b_ren), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .pix_data(b_pix_data), .pix_valid(b_valid), .pix_ready(b_ready),
    .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof), .started(b_started),
    .done(b_done), .error(b_error));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models with 1-cycle read latency, data = address.
  always @(posedge clk) begin
    cyc++;
    if (ren)   rd_data   <= {{(DW-AW){1'b0}}, rd_addr};
    if (b_ren) b_rd_data <= b_rd_addr[15:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sampled mid-cycle: what is seen here transfers at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      dq.delete(); fq.delete();
      issued = 0; xfer = 0; stall_v = 1'b0;
      bx = 0; beol = 0; beof = 0; bsof = 0; blast = 0;
    end else begin
      if (stall_v) chk("hold", {23'd0, pix_valid, pix_data}, {23'd0, 1'b1, stall_d});
      if (ren) chk("occ", 32'((issued - xfer + 1 - ((pix_valid && pix_ready) ? 1 : 0)) <= 2), 32'd1);
      if (pix_valid && pix_ready) begin
        dq.push_back(pix_data);
        fq.push_back({pix_sof, pix_eol, pix_eof});
        xfer++;
        if (pix_eof) eof_cyc = cyc;
      end
      if (ren) issued++;
      stall_v = pix_valid && !pix_ready;
      stall_d = pix_data;
      if (b_ren) blast = 32'(b_rd_addr);
      if (b_valid && b_ready) begin
        bx++;
        if (b_eol) beol++;
        if (b_eof) beof++;
        if (b_sof) bsof++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    done_cyc = cyc;
    pix_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int base);
    logic [11:0] sm, em, fm;
    sm = '0; em = '0; fm = '0;
    chk({tag, "_n"}, 32'(dq.size() - base), 32'd12);
    for (int i = 0; i < 12 && base + i < dq.size(); i++) begin
      chk({tag, "_d"}, 32'(dq[base+i]), 32'(i));
      sm[i] = fq[base+i][2];
      em[i] = fq[base+i][1];
      fm[i] = fq[base+i][0];
    end
    chk({tag, "_sof"}, 32'(sm), 32'h001);
    chk({tag, "_eol"}, 32'(em), 32'h888);
    chk({tag, "_eof"}, 32'(fm), 32'h800);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int base, n;
    reset = 1'b0; start = 1'b0; ack = 1'b0; pix_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    #1;
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_flags", 32'({started, done, error}), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // 1: back-to-back frame and first-pixel latency
    base = dq.size();
    pulse_start();
    chk("t1_started", 32'(started), 32'd1);
    tick();
    chk("t1_lat_n1", 32'(pix_valid), 32'd0);
    tick();
    chk("t1_lat_n2", 32'(pix_valid), 32'd1);
    run_until_done(100, 1'b0);
    chk("t1_done_lat", 32'(done_cyc - eof_cyc), 32'd1);
    chk("t1_addr0", 32'(rd_addr), 32'd0);
    check_frame("t1", base);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_ack", 32'({started, done}), 32'd0);

    // 2: random backpressure
    base = dq.size();
    pulse_start();
    run_until_done(400, 1'b1);
    check_frame("t2", base);
    ack = 1'b1; tick(); ack = 1'b0;

    // 3: start held through the frame and into DONE
    base = dq.size();
    start = 1'b1;
    run_until_done(100, 1'b0);
    repeat (5) tick();
    chk("t3_still_done", 32'(done), 32'd1);
    chk("t3_one_frame", 32'(dq.size() - base), 32'd12);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t3_wait", 32'({started, done}), 32'd0);
    tick();
    chk("t3_restart", 32'(started), 32'd1);
    start = 1'b0;
    base = dq.size();
    run_until_done(100, 1'b0);
    check_frame("t3", base);
    ack = 1'b1; tick(); ack = 1'b0;

    // 4: asynchronous reset mid-frame
    base = dq.size();
    pulse_start();
    n = 0;
    while (dq.size() - base < 5 && n < 100) begin tick(); n++; end
    #3;
    reset = 1'b0;
    #1;
    chk("t4_rst_out", 32'({ren, pix_valid, started, done, error}), 32'd0);
    chk("t4_rst_data", 32'({rd_addr, pix_data}), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    pulse_start();
    run_until_done(100, 1'b0);
    check_frame("t4", 0);
    ack = 1'b1; tick(); ack = 1'b0;

    // 5: long stall on the last pixel
    base = dq.size();
    pulse_start();
    n = 0;
    while (dq.size() - base < 11 && n < 100) begin tick(); n++; end
    pix_ready = 1'b0;
    repeat (50) tick();
    chk("t5_drain", 32'({started, done}), 32'b10);
    chk("t5_head", 32'({pix_valid, pix_data}), 32'h10B);
    pix_ready = 1'b1;
    tick();
    chk("t5_done", 32'(done), 32'd1);
    check_frame("t5", base);
    ack = 1'b1; tick(); ack = 1'b0;

    // 6: full-size frame
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 80000) begin tick(); n++; end
    chk("t6_done", 32'(b_done), 32'd1);
    chk("t6_xfer", 32'(bx), 32'd76800);
    chk("t6_eol", 32'(beol), 32'd240);
    chk("t6_sof_eof", 32'({bsof[7:0], beof[7:0]}), 32'h0101);
    chk("t6_last_addr", 32'(blast), 32'd76799);
    chk("t6_error", 32'({b_error, error}), 32'd0);
    chk("t6_addr0", 32'(b_rd_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
